mem_port_arbiter: RTL and testbench

- Shares the single-port byte-addressed memory between an instruction-fetch requester and a data load/store requester.
- The memory has a combinational read and a synchronous full-word write, so this block sequences every access.
- Sub-word stores are done as read-modify-write.
- Addresses are checked against the memory window, and each requester gets a one-cycle response pulse.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port byte-addressed memory between fetch and data requesters.
// Sub-word stores use read-modify-write. Define ARB_RR_EN for round-robin tie-breaking.
module mem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  // state    | meaning
  // S_IDLE   | waiting for a request
  // S_F_RD   | fetch read
  // S_D_RD   | data load read
  // S_D_WR   | word store write
  // S_RMW_RD | sub-word store, read old word
  // S_RMW_WR | sub-word store, write merged word
  // S_RESP   | one-cycle response pulse to the owner
  typedef enum logic [2:0] {
    S_IDLE, S_F_RD, S_D_RD, S_D_WR, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  localparam logic [32:0] DEPTH33 = 33'(MEM_DEPTH);

  state_t      state, state_next;
  logic        grant_if, grant_d, accept, in_range;
  logic [31:0] acc_addr;
  logic [32:0] offset;
  logic        owner_d, rsp_is_d, rsp_err;
  logic [31:0] addr_q, wdata_q, merge_q, rsp_word;
  logic [1:0]  size_q;
  logic [31:0] if_data_q, d_data_q;
  logic        if_err_q, d_err_q;
`ifdef ARB_RR_EN
  logic        last_if;
`endif

  always_comb begin : arbitrate
`ifdef ARB_RR_EN
    grant_d  = d_req_valid & (~if_req_valid | last_if);
    grant_if = if_req_valid & (~d_req_valid | ~last_if);
`else
    grant_d  = d_req_valid;
    grant_if = if_req_valid & ~d_req_valid;
`endif
    accept   = (state == S_IDLE) & (grant_d | grant_if);
    acc_addr = grant_d ? d_addr : if_addr;
    // 33-bit offset so addresses near the top of the space cannot wrap into range
    offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    in_range = (acc_addr >= BASE_ADDR) && ((offset + 33'd3) < DEPTH33);
  end

  always_ff @(posedge clock) begin : state_reg
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!in_range)      state_next = S_RESP;
          else if (grant_if)  state_next = S_F_RD;
          else if (!d_we)     state_next = S_D_RD;
          else if (d_size[1]) state_next = S_D_WR;
          else                state_next = S_RMW_RD;
        end
      end
      S_F_RD, S_D_RD, S_D_WR, S_RMW_WR: state_next = S_RESP;
      S_RMW_RD:                         state_next = S_RMW_WR;
      S_RESP:                           state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    if_req_ready   = (state == S_IDLE) & grant_if;
    d_req_ready    = (state == S_IDLE) & grant_d;
    busy           = (state != S_IDLE);
    if_rsp_valid   = (state == S_RESP) & ~owner_d;
    d_rsp_valid    = (state == S_RESP) & owner_d;
    if_rsp_data    = if_data_q;
    if_rsp_err     = if_err_q;
    d_rsp_data     = d_data_q;
    d_rsp_err      = d_err_q;
    mem_address    = addr_q;
    mem_data_in    = 32'h0;
    mem_read_write = 1'b0;
    rsp_word       = 32'h0;
    // leaving IDLE straight to RESP only happens for an out-of-range request
    rsp_err        = (state == S_IDLE);
    rsp_is_d       = (state == S_IDLE) ? grant_d : owner_d;
    case (state)
      S_F_RD: rsp_word = mem_data_out;
      S_D_RD: begin
        case (size_q)
          2'b00:   rsp_word = {24'h0, mem_data_out[7:0]};
          2'b01:   rsp_word = {16'h0, mem_data_out[15:0]};
          default: rsp_word = mem_data_out;
        endcase
      end
      S_D_WR: begin
        mem_data_in    = wdata_q;
        mem_read_write = 1'b1;
      end
      S_RMW_WR: begin
        mem_data_in    = size_q[0] ? {merge_q[31:16], wdata_q[15:0]}
                                   : {merge_q[31:8], wdata_q[7:0]};
        mem_read_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin : datapath
    if (!reset) begin
      addr_q    <= 32'h0;
      owner_d   <= 1'b0;
      size_q    <= 2'b00;
      wdata_q   <= 32'h0;
      merge_q   <= 32'h0;
      if_data_q <= 32'h0;
      if_err_q  <= 1'b0;
      d_data_q  <= 32'h0;
      d_err_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_if   <= 1'b1;
`endif
    end else begin
      if (accept) begin
        addr_q  <= acc_addr;
        owner_d <= grant_d;
        size_q  <= d_size;
        wdata_q <= d_wdata;
`ifdef ARB_RR_EN
        last_if <= grant_if;
`endif
      end
      if (state == S_RMW_RD) merge_q <= mem_data_out;
      if (state_next == S_RESP) begin
        if (rsp_is_d) begin
          d_data_q <= rsp_word;
          d_err_q  <= rsp_err;
        end else begin
          if_data_q <= rsp_word;
          if_err_q  <= rsp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized traffic
// checked against a byte-level memory model and transaction latency rules.
module tb_mem_port_arbiter;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_wdata = '0;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write, busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_size(d_size), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write), .mem_data_out(mem_data_out), .busy(busy)
  );

  // 256-byte memory aliased over the window; the reference uses the same aliasing
  logic [7:0]  mem_bytes [256];
  logic [7:0]  ref_bytes [256];
  int          wr_count = 0;
  logic [31:0] last_wdata = '0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0, poke_data = '0;
  int          n_cmp = 0, n_bad = 0;
  bit          last_if_m = 1'b1;

  function automatic logic [7:0] bidx(input logic [31:0] a, input int i);
    logic [31:0] o;
    o = a - BASE + 32'(i);
    return o[7:0];
  endfunction

  always_comb mem_data_out = {mem_bytes[bidx(mem_address, 3)], mem_bytes[bidx(mem_address, 2)],
                              mem_bytes[bidx(mem_address, 1)], mem_bytes[bidx(mem_address, 0)]};

  always @(posedge clock) begin
    if (mem_read_write) begin
      wr_count++;
      last_wdata = mem_data_in;
      for (int i = 0; i < 4; i++) mem_bytes[bidx(mem_address, i)] <= mem_data_in[8*i +: 8];
    end else if (poke_en) begin
      for (int i = 0; i < 4; i++) mem_bytes[bidx(poke_addr, i)] <= poke_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_bytes[bidx(a, 3)], ref_bytes[bidx(a, 2)], ref_bytes[bidx(a, 1)], ref_bytes[bidx(a, 0)]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_bytes[bidx(a, 3)], mem_bytes[bidx(a, 2)], mem_bytes[bidx(a, 1)], mem_bytes[bidx(a, 0)]};
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la - lb + 3 < longint'(DEPTH));
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] w);
    int n;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_bytes[bidx(a, i)] = w[8*i +: 8];
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_bytes[bidx(a, i)] = w[8*i +: 8];
    poke_addr = a;
    poke_data = w;
    poke_en   = 1'b1;
    @(posedge clock);
    #1 poke_en = 1'b0;
  endtask

  task automatic present(input bit is_d, input logic [31:0] a, input bit we,
                         input logic [1:0] size, input logic [31:0] wd);
    if (is_d) begin
      d_req_valid = 1'b1; d_addr = a; d_we = we; d_size = size; d_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_addr = a;
    end
  endtask

  task automatic release_port(input bit is_d);
    if (is_d) d_req_valid = 1'b0;
    else      if_req_valid = 1'b0;
  endtask

  task automatic wait_any(output bit got_d, output int waited);
    waited = 0;
    while (!(d_req_ready || if_req_ready) && waited < 20) begin
      @(negedge clock); #1;
      waited++;
    end
    chk("accept_in_time", 32'(waited < 20), 32'd1);
    chk("single_ready", 32'(d_req_ready & if_req_ready), 32'd0);
    got_d = d_req_ready;
  endtask

  // Called just before the accept edge; follows the transaction to its response.
  task automatic complete(input bit is_d, input logic [31:0] a, input bit we,
                          input logic [1:0] size, input logic [31:0] wd,
                          input string tag, input bit drop_port);
    bit          inr, seen, is_store;
    int          exp_lat, lat, base;
    logic [31:0] w, exp_data;
    inr      = in_window(a);
    is_store = is_d && we;
    w        = ref_word(a);
    exp_data = 32'h0;
    if (!is_d) exp_data = w;
    else if (!we) begin
      case (size)
        2'b00:   exp_data = {24'h0, w[7:0]};
        2'b01:   exp_data = {16'h0, w[15:0]};
        default: exp_data = w;
      endcase
    end
    exp_lat   = !inr ? 1 : (is_store && size < 2'b10) ? 3 : 2;
    last_if_m = !is_d;
    base      = wr_count;
    @(posedge clock);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clock); #1;
      lat++;
      if (drop_port && lat == 1) release_port(is_d);
      seen = is_d ? d_rsp_valid : if_rsp_valid;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(is_d ? d_rsp_err : if_rsp_err), 32'(!inr));
    if (inr) chk({tag, "_data"}, is_d ? d_rsp_data : if_rsp_data, exp_data);
    chk({tag, "_writes"}, 32'(wr_count - base), 32'((inr && is_store) ? 1 : 0));
    if (inr && is_store) begin
      ref_store(a, size, wd);
      chk({tag, "_memword"}, mem_word(a), ref_word(a));
    end
    @(negedge clock); #1;
    chk({tag, "_pulse_width"}, 32'(is_d ? d_rsp_valid : if_rsp_valid), 32'd0);
  endtask

  task automatic req(input bit is_d, input logic [31:0] a, input bit we,
                     input logic [1:0] size, input logic [31:0] wd, input string tag);
    bit got_d;
    int waited;
    @(negedge clock);
    present(is_d, a, we, size, wd);
    #1;
    wait_any(got_d, waited);
    chk({tag, "_grant"}, 32'(got_d), 32'(is_d));
    complete(is_d, a, we, size, wd, tag, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got_d, first_d, exp_d, is_d, we;
    int          waited;
    logic [31:0] a, old, fa, da;
    logic [1:0]  size;

    for (int i = 0; i < 64; i++) poke_word(BASE + 32'(4 * i), $urandom);
    @(negedge clock); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    chk("rst_mem_rw", 32'(mem_read_write), 32'd0);
    chk("rst_rsp_valid", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
    chk("rst_rsp_data", if_rsp_data | d_rsp_data, 32'h0);
    chk("rst_ready", 32'({if_req_ready, d_req_ready}), 32'd0);
    chk("rst_writes", 32'(wr_count), 32'd0);
    reset = 1'b1;

    poke_word(32'h0100_0010, 32'hDEADBEEF);
    req(1'b1, 32'h0100_0010, 1'b0, 2'b10, 32'h0, "word_load");
    chk("word_load_value", d_rsp_data, 32'hDEADBEEF);
    req(1'b0, 32'h0100_0010, 1'b0, 2'b00, 32'h0, "fetch");
    chk("fetch_value", if_rsp_data, 32'hDEADBEEF);
    chk("d_rsp_hold", d_rsp_data, 32'hDEADBEEF);

    poke_word(32'h0100_0020, 32'h11223344);
    req(1'b1, 32'h0100_0020, 1'b1, 2'b00, 32'h0000_00AA, "byte_store");
    chk("byte_store_wdata", last_wdata, 32'h112233AA);
    req(1'b1, 32'h0100_0020, 1'b0, 2'b10, 32'h0, "reload");
    chk("reload_value", d_rsp_data, 32'h112233AA);

    req(1'b1, 32'h00FF_FFFF, 1'b1, 2'b10, 32'h1234_5678, "oor_store");
    poke_word(32'h0100_0030, 32'hCAFEBABE);
    req(1'b1, 32'h0100_0030, 1'b0, 2'b01, 32'h0, "half_load");
    chk("half_load_value", d_rsp_data, 32'h0000BABE);
    req(1'b1, BASE + 32'(DEPTH) - 32'd4, 1'b0, 2'b10, 32'h0, "top_in");
    req(1'b1, BASE + 32'(DEPTH) - 32'd3, 1'b0, 2'b10, 32'h0, "top_out");
    req(1'b0, 32'hFFFF_FFFF, 1'b0, 2'b00, 32'h0, "wrap_out");

    // both requesters held valid through several accepts
    da = BASE + 32'h48;
    fa = BASE + 32'h84;
    @(negedge clock);
    present(1'b1, da, 1'b0, 2'b10, 32'h0);
    present(1'b0, fa, 1'b0, 2'b00, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_any(got_d, waited);
`ifdef ARB_RR_EN
      exp_d = last_if_m;
`else
      exp_d = 1'b1;
`endif
      chk("tie_grant", 32'(got_d), 32'(exp_d));
      if (k > 0) chk("tie_gap", 32'(waited), 32'd0);
      if (got_d) complete(1'b1, da, 1'b0, 2'b10, 32'h0, "tie_d", 1'b0);
      else       complete(1'b0, fa, 1'b0, 2'b00, 32'h0, "tie_f", 1'b0);
    end
    release_port(1'b1);
    release_port(1'b0);

    // simultaneous request, winner drops, loser accepted right after the pulse
    @(negedge clock);
    present(1'b1, da, 1'b0, 2'b10, 32'h0);
    present(1'b0, fa, 1'b0, 2'b00, 32'h0);
    #1;
    wait_any(first_d, waited);
`ifdef ARB_RR_EN
    exp_d = last_if_m;
`else
    exp_d = 1'b1;
`endif
    chk("pair_first", 32'(first_d), 32'(exp_d));
    if (first_d) complete(1'b1, da, 1'b0, 2'b10, 32'h0, "pair_d", 1'b1);
    else         complete(1'b0, fa, 1'b0, 2'b00, 32'h0, "pair_f", 1'b1);
    wait_any(got_d, waited);
    chk("pair_second", 32'(got_d), 32'(!first_d));
    chk("pair_gap", 32'(waited), 32'd0);
    if (got_d) complete(1'b1, da, 1'b0, 2'b10, 32'h0, "pair_d2", 1'b1);
    else       complete(1'b0, fa, 1'b0, 2'b00, 32'h0, "pair_f2", 1'b1);

    // reset while a byte store sits in its read phase
    a = BASE + 32'h40;
    @(negedge clock);
    present(1'b1, a, 1'b1, 2'b00, 32'h55);
    #1;
    wait_any(got_d, waited);
    chk("rstmid_grant", 32'(got_d), 32'd1);
    old = ref_word(a);
    waited = wr_count;
    @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b0;
    d_req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rsp", 32'(d_rsp_valid), 32'd0);
    chk("rstmid_writes", 32'(wr_count - waited), 32'd0);
    chk("rstmid_mem", mem_word(a), old);
    chk("rstmid_rsp_data", d_rsp_data, 32'h0);
    reset = 1'b1;
    last_if_m = 1'b1;

    for (int n = 0; n < 120; n++) begin
      is_d = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1) == 1;
      size = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 16));
        1:       a = BASE + 32'(DEPTH) - 32'd3 + 32'($urandom_range(0, 3));
        2:       a = BASE + 32'(DEPTH) - 32'd4;
        default: a = BASE + 32'($urandom_range(0, 252));
      endcase
      req(is_d, a, we, size, $urandom, is_d ? "rnd_d" : "rnd_f");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
